// File: rtl/calc_times_pkg.sv
// Shared widths, parameter/timing indices and FSM state type for the trapezoidal
// motion-profile timing calculator.
package calc_times_pkg;

  localparam int unsigned PARAM_W  = 32;
  localparam int unsigned TIME_W   = 64;
  localparam int unsigned N_PARAMS = 5;
  localparam int unsigned N_TIMES  = 4;

  localparam int unsigned P_P0 = 0;
  localparam int unsigned P_A  = 1;
  localparam int unsigned P_N  = 2;
  localparam int unsigned P_NA = 3;
  localparam int unsigned P_NC = 4;

  localparam int unsigned T_T1 = 0;
  localparam int unsigned T_T2 = 1;
  localparam int unsigned T_T3 = 2;
  localparam int unsigned T_TT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StMul,
    StScale,
    StSum,
    StDone
  } calc_state_e;

  function automatic logic [TIME_W-1:0] widen(input logic [PARAM_W-1:0] v);
    return {{(TIME_W - PARAM_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/calc_axis_times.sv
// Per-axis timing pipeline: sampled parameters flow through LATCH/MUL/SCALE/SUM
// stages, each register bank loaded while the top-level FSM sits in that state.
module calc_axis_times
  import calc_times_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               sample_i,
  input  calc_state_e        state_i,
  input  logic [PARAM_W-1:0] params_i [0:N_PARAMS-1],
  output logic [TIME_W-1:0]  timing_o [0:N_TIMES-1]
);

  logic [PARAM_W-1:0] p_q [0:N_PARAMS-1];
  logic [TIME_W-1:0]  p0, a, n, na, nc;
  logic [TIME_W-1:0]  nd_d, nd_q, na_p0_d, na_p0_q, na_a_d, na_a_q;
  logic [TIME_W-1:0]  na_nam1_d, na_nam1_q, nd_nd1_d, nd_nd1_q;
  logic               valid_d, valid_q;
  logic [TIME_W-1:0]  pmin_d, pmin_q, half1_d, half1_q, half3_d, half3_q;
  logic [TIME_W-1:0]  t1_d, t1_q, t2_d, t2_q, t3_d, t3_q;
  logic [TIME_W-1:0]  timing_d [0:N_TIMES-1];
  logic [TIME_W-1:0]  timing_q [0:N_TIMES-1];

  always_comb begin
    p0 = widen(p_q[P_P0]);
    a  = widen(p_q[P_A]);
    n  = widen(p_q[P_N]);
    na = widen(p_q[P_NA]);
    nc = widen(p_q[P_NC]);

    nd_d      = n - na - nc;
    na_a_d    = na * a;
    // Operands are zero-extended 32-bit values, so neither test can wrap.
    valid_d   = (na_a_d < p0) && ((na + nc) <= n);
    na_p0_d   = na * p0;
    na_nam1_d = na * (na - 64'd1);
    nd_nd1_d  = nd_d * (nd_d + 64'd1);

    pmin_d  = p0 - na_a_q;
    half1_d = a * (na_nam1_q >> 1);
    half3_d = a * (nd_nd1_q >> 1);

    t1_d = na_p0_q - half1_q;
    t2_d = nc * pmin_q;
    t3_d = nd_q * pmin_q + half3_q;

    timing_d[T_T1] = valid_q ? t1_q : '0;
    timing_d[T_T2] = valid_q ? t2_q : '0;
    timing_d[T_T3] = valid_q ? t3_q : '0;
    timing_d[T_TT] = valid_q ? (t1_q + t2_q + t3_q) : '0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < N_PARAMS; i++) p_q[i] <= '0;
      for (int i = 0; i < N_TIMES; i++) timing_q[i] <= '0;
      nd_q      <= '0;
      valid_q   <= 1'b0;
      na_p0_q   <= '0;
      na_a_q    <= '0;
      na_nam1_q <= '0;
      nd_nd1_q  <= '0;
      pmin_q    <= '0;
      half1_q   <= '0;
      half3_q   <= '0;
      t1_q      <= '0;
      t2_q      <= '0;
      t3_q      <= '0;
    end else begin
      if (sample_i) p_q <= params_i;
      if (state_i == StLatch) begin
        nd_q      <= nd_d;
        valid_q   <= valid_d;
        na_p0_q   <= na_p0_d;
        na_a_q    <= na_a_d;
        na_nam1_q <= na_nam1_d;
        nd_nd1_q  <= nd_nd1_d;
      end
      if (state_i == StMul) begin
        pmin_q  <= pmin_d;
        half1_q <= half1_d;
        half3_q <= half3_d;
      end
      if (state_i == StScale) begin
        t1_q <= t1_d;
        t2_q <= t2_d;
        t3_q <= t3_d;
      end
      if (state_i == StSum) timing_q <= timing_d;
    end
  end

  assign timing_o = timing_q;

endmodule

// File: rtl/calc_times.sv
// Five-axis trapezoidal profile timing calculator: owns the stage FSM and the
// finish handshake; the arithmetic lives in one calc_axis_times per axis.
module calc_times
  import calc_times_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [PARAM_W-1:0] params_x_i  [0:N_PARAMS-1],
  input  logic [PARAM_W-1:0] params_y_i  [0:N_PARAMS-1],
  input  logic [PARAM_W-1:0] params_z_i  [0:N_PARAMS-1],
  input  logic [PARAM_W-1:0] params_e0_i [0:N_PARAMS-1],
  input  logic [PARAM_W-1:0] params_e1_i [0:N_PARAMS-1],
  output logic [TIME_W-1:0]  timing_x_o  [0:N_TIMES-1],
  output logic [TIME_W-1:0]  timing_y_o  [0:N_TIMES-1],
  output logic [TIME_W-1:0]  timing_z_o  [0:N_TIMES-1],
  output logic [TIME_W-1:0]  timing_e0_o [0:N_TIMES-1],
  output logic [TIME_W-1:0]  timing_e1_o [0:N_TIMES-1],
  output logic               finish_o
);

  calc_state_e state_d, state_q;
  logic        finish_d, finish_q;
  logic        sample;

  assign sample = (state_q == StIdle) && start_i;

  always_comb begin
    state_d  = state_q;
    finish_d = finish_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StLatch;
      StLatch: state_d = StMul;
      StMul:   state_d = StScale;
      StScale: state_d = StSum;
      StSum:   state_d = StDone;
      StDone: begin
        // finish always shows for at least one cycle, even if start already dropped.
        if (!finish_q) begin
          finish_d = 1'b1;
        end else if (!start_i) begin
          finish_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        finish_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish_d;
    end
  end

  assign finish_o = finish_q;

  calc_axis_times u_axis_x (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .sample_i (sample),
    .state_i  (state_q),
    .params_i (params_x_i),
    .timing_o (timing_x_o)
  );

  calc_axis_times u_axis_y (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .sample_i (sample),
    .state_i  (state_q),
    .params_i (params_y_i),
    .timing_o (timing_y_o)
  );

  calc_axis_times u_axis_z (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .sample_i (sample),
    .state_i  (state_q),
    .params_i (params_z_i),
    .timing_o (timing_z_o)
  );

  calc_axis_times u_axis_e0 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .sample_i (sample),
    .state_i  (state_q),
    .params_i (params_e0_i),
    .timing_o (timing_e0_o)
  );

  calc_axis_times u_axis_e1 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .sample_i (sample),
    .state_i  (state_q),
    .params_i (params_e1_i),
    .timing_o (timing_e1_o)
  );

endmodule

// File: tb/tb_calc_times.sv
// Scoreboard bench for calc_times: stimulus queues expected timings per run, a
// monitor pops and compares them on every rising finish.
module tb_calc_times;
  import calc_times_pkg::*;

  typedef logic [4:0][3:0][63:0] exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] px [0:4];
  logic [31:0] py [0:4];
  logic [31:0] pz [0:4];
  logic [31:0] pe0 [0:4];
  logic [31:0] pe1 [0:4];
  logic [63:0] tx [0:3];
  logic [63:0] ty [0:3];
  logic [63:0] tz [0:3];
  logic [63:0] te0 [0:3];
  logic [63:0] te1 [0:3];
  logic        finish;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic fin_prev = 1'b0;

  always #5 clk = ~clk;

  calc_times dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .start_i     (start),
    .params_x_i  (px),
    .params_y_i  (py),
    .params_z_i  (pz),
    .params_e0_i (pe0),
    .params_e1_i (pe1),
    .timing_x_o  (tx),
    .timing_y_o  (ty),
    .timing_z_o  (tz),
    .timing_e0_o (te0),
    .timing_e1_o (te1),
    .finish_o    (finish)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] act_t(input int ax, input int j);
    case (ax)
      0:       return tx[j];
      1:       return ty[j];
      2:       return tz[j];
      3:       return te0[j];
      default: return te1[j];
    endcase
  endfunction

  function automatic logic [3:0][63:0] mk(input logic [63:0] t1, input logic [63:0] t2,
                                          input logic [63:0] t3, input logic [63:0] tt);
    logic [3:0][63:0] r;
    r[0] = t1;
    r[1] = t2;
    r[2] = t3;
    r[3] = tt;
    return r;
  endfunction

  task automatic set_axis(input int ax, input logic [31:0] p0, input logic [31:0] a,
                          input logic [31:0] n, input logic [31:0] na, input logic [31:0] nc);
    logic [31:0] v [0:4];
    v = '{p0, a, n, na, nc};
    case (ax)
      0:       px = v;
      1:       py = v;
      2:       pz = v;
      3:       pe0 = v;
      default: pe1 = v;
    endcase
  endtask

  task automatic wait_finish(input int max_cycles);
    int i;
    i = 0;
    while (!finish && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (!finish) begin
      n_err++;
      $display("FAIL finish_timeout: finish=%0b after %0d cycles, expected 1", finish, i);
    end
  endtask

  // Monitor: every rising finish must match the oldest queued expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (finish && !fin_prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_finish: finish=1 with no pending result, expected 0");
        end else begin
          e = sb_q.pop_front();
          for (int ax = 0; ax < 5; ax++)
            for (int j = 0; j < 4; j++)
              check($sformatf("axis%0d_t%0d", ax, j), act_t(ax, j), e[ax][j]);
        end
      end
      fin_prev = finish;
    end
  end

  initial begin
    exp_t e;
    reset_n = 1'b0;
    start   = 1'b0;
    for (int ax = 0; ax < 5; ax++) set_axis(ax, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_finish", {63'd0, finish}, 64'd0);
    check("reset_tx_tt", tx[3], 64'd0);
    check("reset_te0_t2", te0[1], 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Run 1: X nominal, Y invalid (Na*A == P0), E0 zero-decel 64-bit, Z/E1 all-zero invalid.
    set_axis(0, 10000, 83, 600, 102, 6);
    set_axis(1, 1000, 10, 200, 100, 50);
    set_axis(3, 500000, 1, 62500, 600, 61900);
    e    = '0;
    e[0] = mk(592467, 9204, 10820802, 11422473);
    e[3] = mk(299820300, 64'd30912860000, 0, 64'd31212680300);
    sb_q.push_back(e);
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("latency_n%0d", k), {63'd0, finish}, (k == 6) ? 64'd1 : 64'd0);
      if (k == 2) set_axis(0, 1, 1, 1, 1, 1);  // FSM now in MUL
      if (k == 4) check("no_early_output", tx[3], 64'd0);
    end
    repeat (2) @(negedge clk);
    check("finish_hold", {63'd0, finish}, 64'd1);
    start = 1'b0;
    @(negedge clk);
    check("finish_drop", {63'd0, finish}, 64'd0);
    check("retain_tx_tt", tx[3], 64'd11422473);
    check("retain_te0_tt", te0[3], 64'd31212680300);
    reset_n = 1'b0;
    #1;
    check("async_reset_tx_tt", tx[3], 64'd0);
    check("async_reset_te0_t2", te0[1], 64'd0);
    check("async_reset_finish", {63'd0, finish}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Run 2: abort with reset during SCALE, then rerun to completion.
    set_axis(0, 2000, 3, 50, 10, 20);
    set_axis(1, 1000, 10, 200, 100, 50);
    set_axis(2, 100, 5, 10, 0, 10);
    set_axis(3, 500000, 1, 62500, 600, 61900);
    set_axis(4, 100, 1, 10, 5, 6);
    e    = '0;
    e[0] = mk(19865, 39400, 40030, 99295);
    e[2] = mk(0, 1000, 0, 1000);
    e[3] = mk(299820300, 64'd30912860000, 0, 64'd31212680300);
    sb_q.push_back(e);
    start = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    sb_q.delete();
    #1;
    check("abort_finish", {63'd0, finish}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_finish", {63'd0, finish}, 64'd0);
    sb_q.push_back(e);
    start = 1'b1;
    wait_finish(20);
    start = 1'b0;
    @(negedge clk);
    check("run2_finish_drop", {63'd0, finish}, 64'd0);

    // Run 3: start held for only one edge; finish must still pulse once.
    set_axis(0, 10000, 83, 600, 102, 6);
    for (int ax = 1; ax < 5; ax++) set_axis(ax, 0, 0, 0, 0, 0);
    e    = '0;
    e[0] = mk(592467, 9204, 10820802, 11422473);
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(20);
    @(negedge clk);
    check("pulse_drop", {63'd0, finish}, 64'd0);
    @(negedge clk);
    check("pulse_idle", {63'd0, finish}, 64'd0);
    check("pulse_retain_tx_tt", tx[3], 64'd11422473);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
